alu_exec: RTL and testbench

Execute stage 2 of the ALU pipeline. Consumes the registered operands and decoded control produced by the execute preprocessor (stage 1) and computes a registered 32-bit result and carry flag one cycle later. It covers arithmetic/logic, shift and memory-load formatting operations, and holds its last result when no valid operation is presented.

---
 rtl/alu_exec.sv | 153 +++++++++++++++
 tb/tb_alu_exec.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// ALU execute stage 2: registered arith/logic, shift and load-format result.
// Ports:
//   clock, reset (async active-low)
//   enable_arith / enable_shift : operation class qualifiers
//   aluin1, aluin2              : operands (aluin1 = shift source, aluin2 = load data)
//   operation_in, opselect_in   : decoded operation and class from stage 1
//   shift_number                : shift amount 0..31
//   aluout, carry, result_valid : registered result, flag and one-cycle valid
module alu_exec #(
    parameter int unsigned REGISTER_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable_arith,
    input  logic                      enable_shift,
    input  logic [REGISTER_WIDTH-1:0] aluin1,
    input  logic [REGISTER_WIDTH-1:0] aluin2,
    input  logic [2:0]                operation_in,
    input  logic [2:0]                opselect_in,
    input  logic [4:0]                shift_number,
    output logic [REGISTER_WIDTH-1:0] aluout,
    output logic                      carry,
    output logic                      result_valid
);

    localparam logic [2:0] OPSEL_SHIFT = 3'b000;
    localparam logic [2:0] OPSEL_ARITH = 3'b001;
    localparam logic [2:0] OPSEL_MEMRD = 3'b101;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_HADD = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_LHG  = 3'b111;

    localparam logic [2:0] LD_BYTE  = 3'b000;
    localparam logic [2:0] LD_HALF  = 3'b001;
    localparam logic [2:0] LD_WORD  = 3'b011;
    localparam logic [2:0] LD_BYTEU = 3'b100;
    localparam logic [2:0] LD_HALFU = 3'b101;

    logic                      accept_c;
    logic [REGISTER_WIDTH-1:0] result_c;
    logic                      carry_c;
    logic [REGISTER_WIDTH:0]   sum_c;
    logic [REGISTER_WIDTH:0]   diff_c;
    logic [16:0]               hsum_c;
    logic [REGISTER_WIDTH:0]   shl_c;
    logic [REGISTER_WIDTH:0]   shr_c;

    // Next result/flag selection; anything not accepted holds the registers.
    always_comb begin
        accept_c = 1'b0;
        result_c = aluout;
        carry_c  = carry;
        sum_c    = {1'b0, aluin1} + {1'b0, aluin2};
        diff_c   = {1'b0, aluin1} - {1'b0, aluin2};
        hsum_c   = {1'b0, aluin1[15:0]} + {1'b0, aluin2[15:0]};
        // Extra bit beyond the word catches the last bit shifted out;
        // it is naturally zero for a zero shift amount.
        shl_c    = {1'b0, aluin1} << shift_number;
        shr_c    = {aluin1, 1'b0} >> shift_number;

        if (enable_arith && (opselect_in == OPSEL_ARITH)) begin
            accept_c = 1'b1;
            carry_c  = 1'b0;
            case (operation_in)
                OP_ADD: begin
                    result_c = sum_c[REGISTER_WIDTH-1:0];
                    carry_c  = sum_c[REGISTER_WIDTH];
                end
                OP_HADD: begin
                    result_c = {{16{hsum_c[15]}}, hsum_c[15:0]};
                    carry_c  = hsum_c[16];
                end
                OP_SUB: begin
                    result_c = diff_c[REGISTER_WIDTH-1:0];
                    carry_c  = diff_c[REGISTER_WIDTH];
                end
                OP_NOT:  result_c = ~aluin2;
                OP_AND:  result_c = aluin1 & aluin2;
                OP_OR:   result_c = aluin1 | aluin2;
                OP_XOR:  result_c = aluin1 ^ aluin2;
                OP_LHG:  result_c = {aluin2[15:0], 16'h0000};
                default: result_c = aluout;
            endcase
        end else if (enable_arith && (opselect_in == OPSEL_MEMRD)) begin
            case (operation_in)
                LD_BYTE: begin
                    accept_c = 1'b1;
                    carry_c  = 1'b0;
                    result_c = {{24{aluin2[7]}}, aluin2[7:0]};
                end
                LD_BYTEU: begin
                    accept_c = 1'b1;
                    carry_c  = 1'b0;
                    result_c = {24'h000000, aluin2[7:0]};
                end
                LD_HALF: begin
                    accept_c = 1'b1;
                    carry_c  = 1'b0;
                    result_c = {{16{aluin2[15]}}, aluin2[15:0]};
                end
                LD_HALFU: begin
                    accept_c = 1'b1;
                    carry_c  = 1'b0;
                    result_c = {16'h0000, aluin2[15:0]};
                end
                LD_WORD: begin
                    accept_c = 1'b1;
                    carry_c  = 1'b0;
                    result_c = aluin2;
                end
                default: accept_c = 1'b0;
            endcase
        end else if (enable_shift && (opselect_in == OPSEL_SHIFT) && !operation_in[2]) begin
            accept_c = 1'b1;
            case (operation_in[1:0])
                2'b00, 2'b01: begin
                    result_c = shl_c[REGISTER_WIDTH-1:0];
                    carry_c  = shl_c[REGISTER_WIDTH];
                end
                2'b10: begin
                    result_c = shr_c[REGISTER_WIDTH:1];
                    carry_c  = shr_c[0];
                end
                default: begin
                    result_c = $unsigned($signed(aluin1) >>> shift_number);
                    carry_c  = shr_c[0];
                end
            endcase
        end
    end

    // Output registers; hold cycles leave result and flag untouched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            aluout       <= '0;
            carry        <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= accept_c;
            if (accept_c) begin
                aluout <= result_c;
                carry  <= carry_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed boundary cases plus randomized traffic
// checked against a behavioural model of the operation table.
module tb_alu_exec;

    logic        clock;
    logic        reset;
    logic        enable_arith;
    logic        enable_shift;
    logic [31:0] aluin1;
    logic [31:0] aluin2;
    logic [2:0]  operation_in;
    logic [2:0]  opselect_in;
    logic [4:0]  shift_number;
    logic [31:0] aluout;
    logic        carry;
    logic        result_valid;

    typedef struct packed {
        logic        valid;
        logic [31:0] out;
        logic        carry;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_out;
    logic        m_carry;

    alu_exec #(.REGISTER_WIDTH(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable_arith (enable_arith),
        .enable_shift (enable_shift),
        .aluin1       (aluin1),
        .aluin2       (aluin2),
        .operation_in (operation_in),
        .opselect_in  (opselect_in),
        .shift_number (shift_number),
        .aluout       (aluout),
        .carry        (carry),
        .result_valid (result_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural reference: one row of the operation table per branch.
    function automatic exp_t model(input logic ea, input logic es, input logic [2:0] ops,
                                   input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] n,
                                   input logic [31:0] cur, input logic cc);
        exp_t            r;
        longint unsigned s;
        int              k;
        int              sh;
        logic [31:0]     t;
        r.valid = 1'b0;
        r.out   = cur;
        r.carry = cc;
        sh      = int'(n);
        if (ea && ops == 3'b001) begin
            r.valid = 1'b1;
            r.carry = 1'b0;
            case (op)
                3'd0: begin
                    s       = 64'(a) + 64'(b);
                    r.out   = a + b;
                    r.carry = (s > 64'hFFFF_FFFF);
                end
                3'd1: begin
                    k       = int'(a[15:0]) + int'(b[15:0]);
                    t       = 32'(k);
                    r.out   = 32'($signed(t[15:0]));
                    r.carry = (k > 65535);
                end
                3'd2: begin
                    r.out   = a - b;
                    r.carry = (a < b);
                end
                3'd3: r.out = ~b;
                3'd4: r.out = a & b;
                3'd5: r.out = a | b;
                3'd6: r.out = a ^ b;
                default: r.out = b << 16;
            endcase
        end else if (ea && ops == 3'b101) begin
            r.valid = 1'b1;
            r.carry = 1'b0;
            case (op)
                3'b000: r.out = 32'($signed(b[7:0]));
                3'b100: r.out = 32'(b[7:0]);
                3'b001: r.out = 32'($signed(b[15:0]));
                3'b101: r.out = 32'(b[15:0]);
                3'b011: r.out = b;
                default: begin
                    r.valid = 1'b0;
                    r.out   = cur;
                    r.carry = cc;
                end
            endcase
        end else if (es && ops == 3'b000 && op < 3'd4) begin
            r.valid = 1'b1;
            if (op < 3'd2) begin
                r.out   = a << sh;
                r.carry = (sh == 0) ? 1'b0 : a[32 - sh];
            end else begin
                if (op == 3'd2) begin
                    r.out = a >> sh;
                end else begin
                    t = a;
                    for (int i = 0; i < sh; i++) t = {t[31], t[31:1]};
                    r.out = t;
                end
                r.carry = (sh == 0) ? 1'b0 : a[sh - 1];
            end
        end
        return r;
    endfunction

    task automatic drive(input logic ea, input logic es, input logic [2:0] ops,
                         input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] n);
        enable_arith = ea;
        enable_shift = es;
        opselect_in  = ops;
        operation_in = op;
        aluin1       = a;
        aluin2       = b;
        shift_number = n;
    endtask

    // Random/model-checked issue.
    task automatic issue(input logic ea, input logic es, input logic [2:0] ops,
                         input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] n);
        exp_t e;
        @(negedge clock);
        drive(ea, es, ops, op, a, b, n);
        e = model(ea, es, ops, op, a, b, n, m_out, m_carry);
        exp_q.push_back(e);
        m_out   = e.out;
        m_carry = e.carry;
    endtask

    // Directed issue with a hand-computed expectation.
    task automatic issue_exp(input logic ea, input logic es, input logic [2:0] ops,
                             input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] n, input logic ev, input logic [31:0] eo,
                             input logic ec);
        exp_t e;
        @(negedge clock);
        drive(ea, es, ops, op, a, b, n);
        e.valid = ev;
        e.out   = eo;
        e.carry = ec;
        exp_q.push_back(e);
        m_out   = eo;
        m_carry = ec;
    endtask

    task automatic check_now(input string name, input logic [31:0] o, input logic c,
                             input logic v);
        n_tests++;
        if (aluout !== o || carry !== c || result_valid !== v) begin
            n_fail++;
            $display("FAIL %s: got out=%08h carry=%b valid=%b, want out=%08h carry=%b valid=%b",
                     name, aluout, carry, result_valid, o, c, v);
        end
    endtask

    // Monitor: one expectation per driven cycle, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (result_valid !== e.valid || aluout !== e.out || carry !== e.carry) begin
                    n_fail++;
                    $display("FAIL scoreboard @%0t: got out=%08h carry=%b valid=%b, want out=%08h carry=%b valid=%b",
                             $time, aluout, carry, result_valid, e.out, e.carry, e.valid);
                end
            end else if (reset && result_valid !== 1'b0) begin
                n_tests++;
                n_fail++;
                $display("FAIL idle_valid @%0t: got valid=%b, want 0", $time, result_valid);
            end
        end
    end

    initial begin
        logic [2:0] ops_tab [5];
        ops_tab[0] = 3'b001;
        ops_tab[1] = 3'b101;
        ops_tab[2] = 3'b000;
        ops_tab[3] = 3'b100;
        ops_tab[4] = 3'b011;

        reset = 1'b0;
        drive(1'b0, 1'b0, 3'b100, 3'b000, 32'h0, 32'h0, 5'd0);
        m_out   = 32'h0;
        m_carry = 1'b0;
        #12;
        check_now("reset_state", 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        // ADD/SUB/HADD boundaries
        issue_exp(1, 0, 3'b001, 3'b000, 32'hFFFF_FFFF, 32'h1, 5'd0, 1, 32'h0, 1);
        issue_exp(1, 0, 3'b001, 3'b010, 32'h3, 32'h5, 5'd0, 1, 32'hFFFF_FFFE, 1);
        issue_exp(1, 0, 3'b001, 3'b001, 32'h1234_7FFF, 32'h1, 5'd0, 1, 32'hFFFF_8000, 0);
        issue_exp(1, 0, 3'b001, 3'b001, 32'h0000_FFFF, 32'h1, 5'd0, 1, 32'h0, 1);
        // shifts
        issue_exp(0, 1, 3'b000, 3'b011, 32'h8000_0010, 32'h0, 5'd4, 1, 32'hF800_0001, 0);
        issue_exp(0, 1, 3'b000, 3'b000, 32'h8000_0001, 32'h0, 5'd1, 1, 32'h0000_0002, 1);
        issue_exp(0, 1, 3'b000, 3'b010, 32'hDEAD_BEEF, 32'h0, 5'd0, 1, 32'hDEAD_BEEF, 0);
        issue_exp(0, 1, 3'b000, 3'b100, 32'h1, 32'h0, 5'd3, 0, 32'hDEAD_BEEF, 0);
        // loads
        issue_exp(1, 0, 3'b101, 3'b000, 32'h0, 32'h1234_8680, 5'd0, 1, 32'hFFFF_FF80, 0);
        issue_exp(1, 0, 3'b101, 3'b100, 32'h0, 32'h1234_8680, 5'd0, 1, 32'h0000_0080, 0);
        issue_exp(1, 0, 3'b101, 3'b001, 32'h0, 32'h1234_8680, 5'd0, 1, 32'hFFFF_8680, 0);
        issue_exp(1, 0, 3'b101, 3'b101, 32'h0, 32'h1234_8680, 5'd0, 1, 32'h0000_8680, 0);
        issue_exp(1, 0, 3'b101, 3'b011, 32'h0, 32'h1234_8680, 5'd0, 1, 32'h1234_8680, 0);
        issue_exp(1, 0, 3'b101, 3'b010, 32'h0, 32'hAAAA_5555, 5'd0, 0, 32'h1234_8680, 0);
        // carry survives idle cycles
        issue_exp(1, 0, 3'b001, 3'b000, 32'hFFFF_FFFF, 32'h2, 5'd0, 1, 32'h1, 1);
        for (int i = 0; i < 3; i++)
            issue_exp(0, 0, 3'b001, 3'b000, 32'h5, 32'h5, 5'd2, 0, 32'h1, 1);
        // priority / mismatches
        issue_exp(1, 0, 3'b000, 3'b000, 32'h5, 32'h6, 5'd2, 0, 32'h1, 1);
        issue_exp(1, 1, 3'b100, 3'b000, 32'h5, 32'h6, 5'd2, 0, 32'h1, 1);
        issue_exp(1, 1, 3'b001, 3'b110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd8, 1, 32'hFF00_FF00, 0);
        issue_exp(1, 1, 3'b000, 3'b000, 32'h0000_00F1, 32'h0, 5'd4, 1, 32'h0000_0F10, 0);

        // mid-stream reset
        issue_exp(1, 0, 3'b001, 3'b000, 32'h7000_0000, 32'h9000_0001, 5'd0, 1, 32'h1, 1);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check_now("reset_async", 32'h0, 1'b0, 1'b0);
        drive(1, 0, 3'b001, 3'b000, 32'h10, 32'h20, 5'd0);
        @(posedge clock);
        #1;
        check_now("reset_held", 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        drive(0, 0, 3'b100, 3'b000, 32'h0, 32'h0, 5'd0);
        m_out   = 32'h0;
        m_carry = 1'b0;
        reset   = 1'b1;
        issue(1, 0, 3'b001, 3'b010, 32'h0, 32'h1, 5'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ops_tab[$urandom_range(0, 4)], 3'($urandom), $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom,
                  5'($urandom));
        end

        @(negedge clock);
        drive(0, 0, 3'b100, 3'b000, 32'h0, 32'h0, 5'd0);
        repeat (4) @(posedge clock);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
